// File: rtl/multicycle_sequencer.sv
// Control FSM for the multi-cycle RV32 subset core: sequences IF/ID/EX/MEM/WB,
// gates decoder strobes, and guards variable-latency IROM/DRAM handshakes with a watchdog.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             irom_ready_i,
    input  logic             dram_ready_i,
    input  logic             regwen_i,
    input  logic             memrw_i,
    input  logic [1:0]       wbsel_i,
    output logic             irom_req_o,
    output logic             ir_we_o,
    output logic             dram_req_o,
    output logic             dram_we_o,
    output logic             reg_we_o,
    output logic             pc_we_o,
    output logic             instret_o,
    output logic [CNT_W-1:0] instret_cnt_o,
    output logic [2:0]       state_o,
    output logic             err_o
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    localparam logic [1:0] WB_LOAD = 2'b01;

    localparam bit WD_EN = (MEM_TIMEOUT > 0);
    localparam int WAIT_W = WD_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic [WAIT_W-1:0] wait_inc;
    logic              wd_hit;
    logic              err_set;

    // Saturating so a disabled watchdog never wraps back into a small count.
    assign wait_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
    // Threshold cycle: the counter already holds MEM_TIMEOUT not-ready cycles.
    assign wd_hit   = WD_EN && (wait_cnt == WAIT_LIMIT);

    // State register, wait counter, retire counter and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_IF;
            wait_cnt      <= '0;
            instret_cnt_o <= '0;
            err_o         <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (err_set)
                err_o <= 1'b1;
            if (instret_o)
                instret_cnt_o <= instret_cnt_o + 1'b1;
        end
    end

    // Next-state logic; the wait counter is cleared whenever a handshake is not pending.
    always_comb begin
        state_nxt = state;
        wait_nxt  = '0;
        err_set   = 1'b0;
        case (state)
            S_IF: begin
                if (run_i) begin
                    if (irom_ready_i) begin
                        state_nxt = S_ID;
                    end else if (wd_hit) begin
                        state_nxt = S_HALT;
                        err_set   = 1'b1;
                    end else begin
                        wait_nxt = wait_inc;
                    end
                end
            end
            S_ID:  state_nxt = S_EX;
            S_EX:  state_nxt = (memrw_i || wbsel_i == WB_LOAD) ? S_MEM : S_WB;
            S_MEM: begin
                if (dram_ready_i) begin
                    state_nxt = memrw_i ? S_IF : S_WB;
                end else if (wd_hit) begin
                    state_nxt = S_HALT;
                    err_set   = 1'b1;
                end else begin
                    wait_nxt = wait_inc;
                end
            end
            S_WB:   state_nxt = S_IF;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IF;
        endcase
    end

    // Strobes are combinational and forced low during the reset cycle.
    always_comb begin
        irom_req_o = 1'b0;
        ir_we_o    = 1'b0;
        dram_req_o = 1'b0;
        dram_we_o  = 1'b0;
        reg_we_o   = 1'b0;
        pc_we_o    = 1'b0;
        instret_o  = 1'b0;
        if (!rst_i) begin
            case (state)
                S_IF: begin
                    irom_req_o = run_i;
                    ir_we_o    = run_i && irom_ready_i;
                end
                S_MEM: begin
                    dram_req_o = 1'b1;
                    dram_we_o  = memrw_i;
                    if (dram_ready_i && memrw_i) begin
                        pc_we_o   = 1'b1;
                        instret_o = 1'b1;
                    end
                end
                S_WB: begin
                    reg_we_o  = regwen_i;
                    pc_we_o   = 1'b1;
                    instret_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-scenario tasks compare a packed
// output vector against hand-computed per-cycle tables.
module tb_multicycle_sequencer;

    logic clk = 1'b0;
    logic rst, run, irom_ready, dram_ready, regwen, memrw;
    logic [1:0] wbsel;

    logic irom_req, ir_we, dram_req, dram_we, reg_we, pc_we, instret, err;
    logic [31:0] cnt;
    logic [2:0]  state;

    logic irom_req4, ir_we4, dram_req4, dram_we4, reg_we4, pc_we4, instret4, err4;
    logic [3:0]  cnt4;
    logic [2:0]  state4;

    int checks = 0;
    int failures = 0;

    // {state, irom_req, ir_we, dram_req, dram_we, reg_we, pc_we, instret}
    logic [9:0] obs;
    assign obs = {state, irom_req, ir_we, dram_req, dram_we, reg_we, pc_we, instret};

    always #5 clk = ~clk;

    multicycle_sequencer #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .run_i(run), .irom_ready_i(irom_ready),
        .dram_ready_i(dram_ready), .regwen_i(regwen), .memrw_i(memrw), .wbsel_i(wbsel),
        .irom_req_o(irom_req), .ir_we_o(ir_we), .dram_req_o(dram_req), .dram_we_o(dram_we),
        .reg_we_o(reg_we), .pc_we_o(pc_we), .instret_o(instret),
        .instret_cnt_o(cnt), .state_o(state), .err_o(err)
    );

    // Narrow counter, watchdog disabled.
    multicycle_sequencer #(.MEM_TIMEOUT(0), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .run_i(run), .irom_ready_i(irom_ready),
        .dram_ready_i(dram_ready), .regwen_i(regwen), .memrw_i(memrw), .wbsel_i(wbsel),
        .irom_req_o(irom_req4), .ir_we_o(ir_we4), .dram_req_o(dram_req4), .dram_we_o(dram_we4),
        .reg_we_o(reg_we4), .pc_we_o(pc_we4), .instret_o(instret4),
        .instret_cnt_o(cnt4), .state_o(state4), .err_o(err4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; run = 1'b1; irom_ready = 1'b1; dram_ready = 1'b1;
        regwen = 1'b1; memrw = 1'b0; wbsel = 2'b00;
        @(negedge clk);
        checks++;
        if (obs[6:0] !== 7'b0 || {irom_req4, ir_we4} !== 2'b00) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=%b", obs[6:0], 7'b0);
        end
        tick;
        rst = 1'b0; run = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 10'b000_0000000 || cnt !== 32'd0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got obs=%b cnt=%0d err=%b exp obs=0 cnt=0 err=0", obs, cnt, err);
        end
        tick;
    endtask

    task automatic pause_check(input string name, input logic [31:0] exp_cnt);
        run = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 10'b000_0000000 || cnt !== exp_cnt) begin
            failures++;
            $display("FAIL %s_retired got obs=%b cnt=%0d exp obs=0 cnt=%0d", name, obs, cnt, exp_cnt);
        end
        tick;
    endtask

    task automatic test_add;
        logic [9:0] exp [4];
        exp = '{10'b000_1100000, 10'b001_0000000, 10'b010_0000000, 10'b100_0000111};
        run = 1'b1; irom_ready = 1'b1; dram_ready = 1'b0;
        regwen = 1'b1; wbsel = 2'b00; memrw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL add[%0d] got=%b exp=%b", i, obs, exp[i]);
            end
            tick;
        end
        pause_check("add", 32'd1);
    endtask

    task automatic test_load;
        logic [9:0] exp [8];
        logic       dr  [8];
        exp = '{10'b000_1100000, 10'b001_0000000, 10'b010_0000000,
                10'b011_0010000, 10'b011_0010000, 10'b011_0010000, 10'b011_0010000,
                10'b100_0000111};
        dr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        run = 1'b1; irom_ready = 1'b1;
        regwen = 1'b1; wbsel = 2'b01; memrw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dram_ready = dr[i];
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL load[%0d] got=%b exp=%b", i, obs, exp[i]);
            end
            tick;
        end
        dram_ready = 1'b0;
        pause_check("load", 32'd2);
    endtask

    // regwen held high to show the store never writes the register file.
    task automatic test_store;
        logic [9:0] exp [4];
        exp = '{10'b000_1100000, 10'b001_0000000, 10'b010_0000000, 10'b011_0011011};
        run = 1'b1; irom_ready = 1'b1; dram_ready = 1'b1;
        regwen = 1'b1; wbsel = 2'b00; memrw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL store[%0d] got=%b exp=%b", i, obs, exp[i]);
            end
            tick;
        end
        dram_ready = 1'b0;
        pause_check("store", 32'd3);
    endtask

    // 15 not-ready cycles, then ready exactly on the threshold cycle.
    task automatic test_wait_boundary;
        logic [9:0] e;
        run = 1'b1; dram_ready = 1'b0;
        regwen = 1'b0; wbsel = 2'b00; memrw = 1'b0;
        for (int i = 0; i < 19; i++) begin
            irom_ready = (i == 15);
            if (i < 15)       e = 10'b000_1000000;
            else if (i == 15) e = 10'b000_1100000;
            else if (i == 16) e = 10'b001_0000000;
            else if (i == 17) e = 10'b010_0000000;
            else              e = 10'b100_0000011;
            @(negedge clk);
            checks++;
            if (obs !== e || err !== 1'b0) begin
                failures++;
                $display("FAIL boundary[%0d] got=%b err=%b exp=%b err=0", i, obs, err, e);
            end
            tick;
        end
        pause_check("boundary", 32'd4);
    endtask

    task automatic test_reset_mid_mem;
        logic [9:0] exp [5];
        exp = '{10'b000_1100000, 10'b001_0000000, 10'b010_0000000,
                10'b011_0010000, 10'b011_0010000};
        run = 1'b1; irom_ready = 1'b1; dram_ready = 1'b0;
        regwen = 1'b1; wbsel = 2'b01; memrw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                failures++;
                $display("FAIL midmem[%0d] got=%b exp=%b", i, obs, exp[i]);
            end
            tick;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs[6:0] !== 7'b0) begin
            failures++;
            $display("FAIL midmem_rst_strobes got=%b exp=%b", obs[6:0], 7'b0);
        end
        tick;
        rst = 1'b0; run = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 10'b000_0000000 || cnt !== 32'd0 || err !== 1'b0) begin
            failures++;
            $display("FAIL midmem_after got obs=%b cnt=%0d err=%b exp obs=0 cnt=0 err=0", obs, cnt, err);
        end
        tick;
    endtask

    task automatic test_pause;
        run = 1'b0; dram_ready = 1'b0;
        for (int i = 0; i < 100; i++) begin
            irom_ready = i[0];
            @(negedge clk);
            checks++;
            if (obs !== 10'b000_0000000 || err !== 1'b0) begin
                failures++;
                $display("FAIL pause[%0d] got=%b err=%b exp=%b err=0", i, obs, err, 10'b0);
            end
            tick;
        end
    endtask

    task automatic test_timeout;
        logic [1:0] k;
        run = 1'b1; irom_ready = 1'b0; dram_ready = 1'b0;
        regwen = 1'b0; wbsel = 2'b00; memrw = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 10'b000_1000000 || err !== 1'b0) begin
                failures++;
                $display("FAIL timeout_wait[%0d] got=%b err=%b exp=%b err=0", i, obs, err, 10'b000_1000000);
            end
            tick;
        end
        irom_ready = 1'b1; dram_ready = 1'b1; regwen = 1'b1;
        for (int i = 0; i < 10; i++) begin
            k = 2'(i);
            run = k[0]; memrw = k[1];
            @(negedge clk);
            checks++;
            if (obs !== 10'b101_0000000 || err !== 1'b1) begin
                failures++;
                $display("FAIL halt[%0d] got=%b err=%b exp=%b err=1", i, obs, err, 10'b101_0000000);
            end
            tick;
        end
        @(negedge clk);
        checks++;
        if (err4 !== 1'b0 || state4 === 3'd5) begin
            failures++;
            $display("FAIL wd_disabled got state=%0d err=%b exp state!=5 err=0", state4, err4);
        end
        tick;
    endtask

    task automatic test_wrap;
        logic [3:0] e4;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        run = 1'b1; irom_ready = 1'b1; dram_ready = 1'b0;
        regwen = 1'b1; wbsel = 2'b00; memrw = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 10'b000_1100000 || err !== 1'b0 || cnt4 !== 4'd0) begin
            failures++;
            $display("FAIL halt_reset got obs=%b err=%b cnt4=%0d exp obs=%b err=0 cnt4=0",
                     obs, err, cnt4, 10'b000_1100000);
        end
        for (int n = 1; n <= 16; n++) begin
            repeat (4) tick;
            e4 = 4'(n);
            @(negedge clk);
            checks++;
            if (cnt4 !== e4 || cnt !== 32'(n)) begin
                failures++;
                $display("FAIL wrap[%0d] got cnt4=%0d cnt=%0d exp cnt4=%0d cnt=%0d", n, cnt4, cnt, e4, n);
            end
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_load;
        test_store;
        test_wait_boundary;
        test_reset_mid_mem;
        test_pause;
        test_timeout;
        test_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle FSM for the RV32 subset core (add/sub/logic/shift, imm forms, lw/sw, beq/bne/blt/bge, lui, jal/jalr).
- Sequences fetch, decode, execute, memory and writeback, so one instruction-ROM port and one data-RAM port are used only in their own phase.
- Gates the decoder's register-write and memory-write strobes, and issues the PC/IR load enables.
- Handles variable-latency IROM/DRAM handshakes with a watchdog timeout.

Parameters:
- MEM_TIMEOUT, 15: max wait cycles for irom_ready_i/dram_ready_i before error; 0 disables the watchdog.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk_i  in  1  core clock (only clock).
- rst_i  in  1  synchronous, active-high reset.
- run_i  in  1  1 = allow new fetches; 0 = pause at next fetch boundary.
- irom_ready_i  in  1  IROM data valid; sampled only while irom_req_o=1.
- dram_ready_i  in  1  DRAM access done; sampled only while dram_req_o=1.
- regwen_i  in  1  decoder register-write request.
- memrw_i  in  1  decoder: 1 = store (sw).
- wbsel_i  in  2  decoder writeback select; 2'b01 = load (lw).
- irom_req_o  out  1  fetch request.
- ir_we_o  out  1  one-cycle pulse: latch instruction register.
- dram_req_o  out  1  data access request.
- dram_we_o  out  1  data write strobe.
- reg_we_o  out  1  gated register-file write enable.
- pc_we_o  out  1  one-cycle pulse: PC <= next PC (the pcsel mux is outside this block).
- instret_o  out  1  one-cycle pulse per retired instruction.
- instret_cnt_o  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W.
- state_o  out  3  current state encoding.
- err_o  out  1  sticky watchdog error.

Behaviour:
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Codes 6/7 are illegal and go to IF next cycle.
- Reset (rst_i=1 at a clock edge, in any state including mid-access):
  - state=IF, wait counter=0, instret_cnt_o=0, err_o=0.
  - All strobes and requests are 0 during the reset cycle.
- All strobes are combinational from state and inputs. State, counters and err_o are registered.
- IF:
  - irom_req_o=run_i.
  - If run_i=0: stay in IF; the wait counter holds at 0.
  - If run_i=1 and irom_ready_i=1: ir_we_o=1, go to ID, clear the wait counter. Ready in the same cycle as request is legal (zero-wait ROM).
  - Otherwise increment the wait counter.
- ID: one cycle, no strobes, go to EX. Decoder inputs are valid from ID onward.
- EX:
  - One cycle, no strobes.
  - If memrw_i=1 or wbsel_i=2'b01, go to MEM; else go to WB.
- MEM:
  - dram_req_o=1, dram_we_o=memrw_i.
  - If dram_ready_i=1 and store: pc_we_o=1, instret_o=1, go to IF.
  - If dram_ready_i=1 and load: go to WB.
  - Otherwise increment the wait counter.
  - dram_we_o is never asserted outside MEM.
- WB: reg_we_o=regwen_i, pc_we_o=1, instret_o=1, go to IF. This covers branches and jumps; the taken/not-taken choice lives in pcsel.
- Latency per instruction, with zero-wait memories:
  - ALU/branch/jump: 4 cycles (IF, ID, EX, WB).
  - Store: 4 cycles (IF, ID, EX, MEM).
  - Load: 5 cycles.
  - Each memory wait cycle adds 1.
- Watchdog:
  - The wait counter counts consecutive not-ready cycles in IF (while run_i=1) or in MEM.
  - When it reaches MEM_TIMEOUT and ready is still 0 on that cycle: go to HALT, set err_o=1.
  - Ready arriving on the same cycle as the threshold wins (no error).
- HALT: all strobes 0. Stay in HALT until rst_i; run_i is ignored.
- instret_cnt_o increments on every instret_o pulse and wraps from all-ones to 0.
- Dropping run_i outside IF does not abort the current instruction; it takes effect at the next IF.

Test Plan:
- Reset, run_i=1, zero-wait memories, add instruction (regwen_i=1, wbsel_i=00, memrw_i=0) → state_o 0,1,2,4,0; ir_we_o pulses in cycle 1, reg_we_o/pc_we_o/instret_o in cycle 4; instret_cnt_o=1.
- lw (wbsel_i=01, regwen_i=1), DRAM ready after 3 wait cycles → dram_req_o high 4 cycles, dram_we_o=0, then WB with reg_we_o=1; 8 cycles total.
- sw (memrw_i=1, regwen_i=0), zero-wait → dram_we_o=1 for one cycle in MEM with pc_we_o=1 and instret_o=1 in the same cycle; reg_we_o never 1; next state IF.
- MEM_TIMEOUT=15, irom_ready_i held 0 → after 15 wait cycles state_o=5 and err_o=1; both stay there with irom_ready_i=1 and run_i toggling until rst_i.
- Boundary: irom_ready_i=1 on exactly the threshold cycle → ID entered, err_o=0. run_i=0 in IF → irom_req_o=0, no timeout after 100 cycles.
- rst_i asserted mid-MEM (load waiting) → next cycle state_o=0, dram_req_o=0, no reg_we_o; instret_cnt_o=0, err_o=0. Preload instret_cnt_o near wrap with CNT_W=4: 16 retirements → 0.
